wb_snoop_responder: RTL and testbench

- Per-core, cache-side snoop responder. One instance per core.
- Consumes the multi-core interconnect's broadcast snoop request (address plus request level) and drives that core's slice of the snoop ack, hit and data return.
- Looks up the core's data-cache tag store. Invalidates a matching line. Supplies the requested word when the line is dirty.
- Stalls the core's own cache accesses while a snoop holds the tag/data ports.

---
 rtl/wb_snoop_responder.sv | 182 ++++++++++++++++++
 tb/tb_wb_snoop_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_snoop_responder.sv
// wb_snoop_responder
//
// Per-core snoop responder on the cache side. It takes the interconnect's broadcast snoop
// (address plus a request level), looks the line up in this core's data-cache tag store,
// invalidates a matching line and, when the line is dirty, returns the requested word with
// the ack. While a snoop owns the tag/data ports, the core's own cache accesses are stalled.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, asynchronous active-high reset
//   snoop_adr_i, snoop_req_i    snoop address and request level (held until ack)
//   snoop_ack_o                 one-cycle response pulse
//   snoop_hit_o, snoop_dat_o    dirty-data flag and snooped word, valid with ack
//   cache_busy_i                core cache mid-access; the snoop waits for it
//   snoop_stall_o               blocks new core cache accesses
//   tag_rd_*                    tag-store read port (1-cycle latency)
//   dat_rd_*                    data-store read port (1-cycle latency)
//   inv_we_o, inv_idx_o         line invalidate strobe (clears valid and dirty)

module wb_snoop_responder #(
   parameter int unsigned AW       = 32,
   parameter int unsigned DW       = 32,
   parameter int unsigned IDX_W    = 8,
   parameter int unsigned OFFSET_W = 4,
   localparam int unsigned TAG_W   = AW - IDX_W - OFFSET_W
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   input  logic [AW-1:0]             snoop_adr_i,
   input  logic                      snoop_req_i,
   output logic                      snoop_ack_o,
   output logic                      snoop_hit_o,
   output logic [DW-1:0]             snoop_dat_o,
   input  logic                      cache_busy_i,
   output logic                      snoop_stall_o,
   output logic                      tag_rd_en_o,
   output logic [IDX_W-1:0]          tag_rd_idx_o,
   input  logic [TAG_W-1:0]          tag_rd_tag_i,
   input  logic                      tag_rd_valid_i,
   input  logic                      tag_rd_dirty_i,
   output logic                      dat_rd_en_o,
   output logic [IDX_W+OFFSET_W-3:0] dat_rd_adr_o,
   input  logic [DW-1:0]             dat_rd_dat_i,
   output logic                      inv_we_o,
   output logic [IDX_W-1:0]          inv_idx_o
);

   localparam int unsigned WORD_W = OFFSET_W - 2;

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StPend    = 3'd1;
   localparam logic [2:0] StLookup  = 3'd2;
   localparam logic [2:0] StCompare = 3'd3;
   localparam logic [2:0] StInv     = 3'd4;
   localparam logic [2:0] StData    = 3'd5;
   localparam logic [2:0] StResp    = 3'd6;
   localparam logic [2:0] StDone    = 3'd7;

   logic [2:0]    state_q, state_d;
   logic [AW-1:0] adr_q, adr_d;
   logic [DW-1:0] dat_q, dat_d;
   logic          resp_hit_q, resp_hit_d;

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic [WORD_W-1:0] word;
   logic              lookup_hit;
   logic              unused_adr_bits;

   assign idx  = adr_q[OFFSET_W+IDX_W-1:OFFSET_W];
   assign tag  = adr_q[AW-1:OFFSET_W+IDX_W];
   assign word = adr_q[OFFSET_W-1:2];

   // Byte-within-word bits play no part in a word-granular snoop.
   assign unused_adr_bits = ^adr_q[1:0];

   assign lookup_hit = tag_rd_valid_i && (tag_rd_tag_i == tag);

   always_comb begin
      state_d    = state_q;
      adr_d      = adr_q;
      dat_d      = dat_q;
      resp_hit_d = resp_hit_q;
      unique case (state_q)
         StIdle: begin
            if (snoop_req_i) begin
               adr_d      = snoop_adr_i;
               resp_hit_d = 1'b0;
               state_d    = cache_busy_i ? StPend : StLookup;
            end
         end
         StPend: begin
            if (!snoop_req_i)       state_d = StIdle;
            else if (!cache_busy_i) state_d = StLookup;
         end
         StLookup: begin
            state_d = snoop_req_i ? StCompare : StIdle;
         end
         StCompare: begin
            // An abort here leaves the line untouched: nothing has been modified yet.
            if (!snoop_req_i) begin
               state_d = StIdle;
            end else if (!lookup_hit) begin
               state_d = StResp;
            end else begin
               resp_hit_d = tag_rd_dirty_i;
               state_d    = tag_rd_dirty_i ? StData : StInv;
            end
         end
         // The invalidate strobe has already fired this cycle, so an abort only skips the ack.
         StInv:  state_d = snoop_req_i ? StResp : StIdle;
         StData: state_d = snoop_req_i ? StResp : StIdle;
         StResp: begin
            // Data-store read issued in DATA arrives this cycle; keep it for later cycles.
            if (resp_hit_q) dat_d = dat_rd_dat_i;
            state_d = StDone;
         end
         StDone: begin
            // Wait for the request to drop so a held level cannot start a second snoop.
            if (!snoop_req_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q    <= StIdle;
         adr_q      <= '0;
         dat_q      <= '0;
         resp_hit_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         adr_q      <= adr_d;
         dat_q      <= dat_d;
         resp_hit_q <= resp_hit_d;
      end
   end

   always_comb begin
      snoop_ack_o   = 1'b0;
      snoop_hit_o   = 1'b0;
      snoop_dat_o   = dat_q;
      snoop_stall_o = 1'b0;
      tag_rd_en_o   = 1'b0;
      tag_rd_idx_o  = '0;
      dat_rd_en_o   = 1'b0;
      dat_rd_adr_o  = '0;
      inv_we_o      = 1'b0;
      inv_idx_o     = '0;
      unique case (state_q)
         StPend: snoop_stall_o = 1'b1;
         StLookup: begin
            snoop_stall_o = 1'b1;
            tag_rd_en_o   = 1'b1;
            tag_rd_idx_o  = idx;
         end
         StCompare: snoop_stall_o = 1'b1;
         StInv: begin
            snoop_stall_o = 1'b1;
            inv_we_o      = 1'b1;
            inv_idx_o     = idx;
         end
         StData: begin
            // Read and invalidate together: the read port sees the old contents this cycle.
            snoop_stall_o = 1'b1;
            dat_rd_en_o   = 1'b1;
            dat_rd_adr_o  = {idx, word};
            inv_we_o      = 1'b1;
            inv_idx_o     = idx;
         end
         StResp: begin
            snoop_stall_o = 1'b1;
            snoop_ack_o   = 1'b1;
            snoop_hit_o   = resp_hit_q;
            // Present the returning word alongside the ack; dat_q holds it afterwards.
            if (resp_hit_q) snoop_dat_o = dat_rd_dat_i;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_snoop_responder.sv
module tb_wb_snoop_responder;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i;
   logic [31:0] snoop_adr_i;
   logic        snoop_req_i;
   logic        snoop_ack_o;
   logic        snoop_hit_o;
   logic [31:0] snoop_dat_o;
   logic        cache_busy_i;
   logic        snoop_stall_o;
   logic        tag_rd_en_o;
   logic [7:0]  tag_rd_idx_o;
   logic [19:0] tag_rd_tag_i;
   logic        tag_rd_valid_i;
   logic        tag_rd_dirty_i;
   logic        dat_rd_en_o;
   logic [9:0]  dat_rd_adr_o;
   logic [31:0] dat_rd_dat_i;
   logic        inv_we_o;
   logic [7:0]  inv_idx_o;

   int checks = 0;
   int errors = 0;

   always #5 wb_clk_i = ~wb_clk_i;

   wb_snoop_responder dut (
      .wb_clk_i       (wb_clk_i),
      .wb_rst_i       (wb_rst_i),
      .snoop_adr_i    (snoop_adr_i),
      .snoop_req_i    (snoop_req_i),
      .snoop_ack_o    (snoop_ack_o),
      .snoop_hit_o    (snoop_hit_o),
      .snoop_dat_o    (snoop_dat_o),
      .cache_busy_i   (cache_busy_i),
      .snoop_stall_o  (snoop_stall_o),
      .tag_rd_en_o    (tag_rd_en_o),
      .tag_rd_idx_o   (tag_rd_idx_o),
      .tag_rd_tag_i   (tag_rd_tag_i),
      .tag_rd_valid_i (tag_rd_valid_i),
      .tag_rd_dirty_i (tag_rd_dirty_i),
      .dat_rd_en_o    (dat_rd_en_o),
      .dat_rd_adr_o   (dat_rd_adr_o),
      .dat_rd_dat_i   (dat_rd_dat_i),
      .inv_we_o       (inv_we_o),
      .inv_idx_o      (inv_idx_o)
   );

   // Cycle numbers count clock edges after the IDLE cycle that samples the request (0 = none).
   typedef struct {
      logic [31:0] adr;
      logic [19:0] tag;
      logic        valid;
      logic        dirty;
      logic [31:0] dat;
      int          busy;
      int          exp_tag_at;
      logic [7:0]  exp_idx;
      int          exp_inv_at;
      int          exp_dat_at;
      logic [9:0]  exp_dat_adr;
      int          exp_ack_at;
      logic        exp_hit;
   } vec_t;

   vec_t        vecs[7];
   logic [31:0] last_dat;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_line(input vec_t v);
      snoop_adr_i    = v.adr;
      tag_rd_tag_i   = v.tag;
      tag_rd_valid_i = v.valid;
      tag_rd_dirty_i = v.dirty;
      dat_rd_dat_i   = v.dat;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " ack"},   {63'd0, snoop_ack_o},   64'd0);
      check({tag, " hit"},   {63'd0, snoop_hit_o},   64'd0);
      check({tag, " dat"},   {32'd0, snoop_dat_o},   64'd0);
      check({tag, " stall"}, {63'd0, snoop_stall_o}, 64'd0);
      check({tag, " tag_en"},{63'd0, tag_rd_en_o},   64'd0);
      check({tag, " tag_idx"},{56'd0, tag_rd_idx_o}, 64'd0);
      check({tag, " dat_en"},{63'd0, dat_rd_en_o},   64'd0);
      check({tag, " dat_adr"},{54'd0, dat_rd_adr_o}, 64'd0);
      check({tag, " inv_we"},{63'd0, inv_we_o},      64'd0);
      check({tag, " inv_idx"},{56'd0, inv_idx_o},    64'd0);
   endtask

   // Called #1 after a rising edge; request is sampled by the next edge.
   task automatic run_vec(input vec_t v, input int vi);
      int ack_cnt = 0, ack_at = 0, inv_cnt = 0, inv_at = 0, rd_cnt = 0, rd_at = 0;
      int tag_cnt = 0, tag_at = 0, stall_bad = 0, stray_hit = 0;
      logic hit_at_ack = 1'b0;
      logic [31:0] dat_at_ack = '0;
      logic [7:0]  inv_idx_seen = '0, tag_idx_seen = '0;
      logic [9:0]  dat_adr_seen = '0;
      string p = $sformatf("vec%0d", vi);
      set_line(v);
      snoop_req_i  = 1'b1;
      cache_busy_i = (v.busy > 0);
      for (int k = 1; k <= 24; k++) begin
         @(posedge wb_clk_i);
         #1;
         if (snoop_ack_o) begin
            ack_cnt++;
            if (ack_at == 0) begin
               ack_at     = k;
               hit_at_ack = snoop_hit_o;
               dat_at_ack = snoop_dat_o;
            end
         end
         if (inv_we_o) begin
            inv_cnt++;
            inv_at       = k;
            inv_idx_seen = inv_idx_o;
         end
         if (dat_rd_en_o) begin
            rd_cnt++;
            rd_at        = k;
            dat_adr_seen = dat_rd_adr_o;
         end
         if (tag_rd_en_o) begin
            tag_cnt++;
            tag_at       = k;
            tag_idx_seen = tag_rd_idx_o;
         end
         if (tag_rd_en_o && cache_busy_i) stall_bad++;
         if ((k <= v.exp_ack_at) != snoop_stall_o) stall_bad++;
         if (snoop_hit_o && !snoop_ack_o) stray_hit++;
         if (k == v.busy) cache_busy_i = 1'b0;
         // Hold the request three cycles past the ack; a stuck level must not re-trigger.
         if ((ack_at != 0 && k == ack_at + 3) || k == 20) snoop_req_i = 1'b0;
      end
      if (v.exp_hit) last_dat = v.dat;
      check({p, " ack_count"}, ack_cnt, 1);
      check({p, " ack_cycle"}, ack_at, v.exp_ack_at);
      check({p, " hit"}, {63'd0, hit_at_ack}, {63'd0, v.exp_hit});
      if (v.exp_hit) check({p, " dat_at_ack"}, {32'd0, dat_at_ack}, {32'd0, v.dat});
      check({p, " tag_rd_count"}, tag_cnt, 1);
      check({p, " tag_rd_cycle"}, tag_at, v.exp_tag_at);
      check({p, " tag_rd_idx"}, {56'd0, tag_idx_seen}, {56'd0, v.exp_idx});
      check({p, " inv_count"}, inv_cnt, (v.exp_inv_at != 0) ? 1 : 0);
      check({p, " inv_cycle"}, inv_at, v.exp_inv_at);
      if (v.exp_inv_at != 0) check({p, " inv_idx"}, {56'd0, inv_idx_seen}, {56'd0, v.exp_idx});
      check({p, " dat_rd_count"}, rd_cnt, (v.exp_dat_at != 0) ? 1 : 0);
      check({p, " dat_rd_cycle"}, rd_at, v.exp_dat_at);
      if (v.exp_dat_at != 0) check({p, " dat_rd_adr"}, {54'd0, dat_adr_seen}, {54'd0, v.exp_dat_adr});
      check({p, " stall_profile"}, stall_bad, 0);
      check({p, " stray_hit"}, stray_hit, 0);
      check({p, " dat_hold"}, {32'd0, snoop_dat_o}, {32'd0, last_dat});
   endtask

   initial begin
      //          adr           tag       v     d     dat           busy tag idx    inv dat adr    ack hit
      vecs[0] = '{32'h0001_2344, 20'h00013, 1'b1, 1'b0, 32'hDEADBEEF, 0, 1, 8'h34, 0, 0, 10'h0D1, 3, 1'b0};
      vecs[1] = '{32'h0001_2344, 20'h00012, 1'b1, 1'b0, 32'hDEADBEEF, 0, 1, 8'h34, 3, 0, 10'h0D1, 4, 1'b0};
      vecs[2] = '{32'h0001_2344, 20'h00012, 1'b1, 1'b1, 32'hDEADBEEF, 0, 1, 8'h34, 3, 3, 10'h0D1, 4, 1'b1};
      vecs[3] = '{32'h0001_2344, 20'h00013, 1'b1, 1'b0, 32'hDEADBEEF, 5, 6, 8'h34, 0, 0, 10'h0D1, 8, 1'b0};
      vecs[4] = '{32'h0001_2344, 20'h00012, 1'b0, 1'b1, 32'hDEADBEEF, 0, 1, 8'h34, 0, 0, 10'h0D1, 3, 1'b0};
      vecs[5] = '{32'hABCD_EF0C, 20'hABCDE, 1'b1, 1'b1, 32'h12345678, 2, 3, 8'hF0, 5, 5, 10'h3C3, 6, 1'b1};
      vecs[6] = '{32'hABCD_EF0C, 20'hABCDF, 1'b1, 1'b1, 32'hCAFEF00D, 0, 1, 8'hF0, 0, 0, 10'h3C3, 3, 1'b0};
      last_dat = '0;

      wb_rst_i     = 1'b1;
      snoop_req_i  = 1'b0;
      cache_busy_i = 1'b0;
      set_line(vecs[0]);
      #1;
      check_all_zero("reset");
      repeat (2) @(posedge wb_clk_i);
      #1;
      wb_rst_i = 1'b0;

      // Reset while in DATA: everything drops at once, without waiting for a clock edge.
      set_line(vecs[2]);
      snoop_req_i = 1'b1;
      repeat (3) @(posedge wb_clk_i);
      #1;
      check("rstdata dat_rd_en", {63'd0, dat_rd_en_o}, 64'd1);
      check("rstdata inv_we", {63'd0, inv_we_o}, 64'd1);
      check("rstdata dat_rd_adr", {54'd0, dat_rd_adr_o}, 64'h0D1);
      #2;
      wb_rst_i    = 1'b1;
      snoop_req_i = 1'b0;
      #1;
      check_all_zero("rstdata");
      @(posedge wb_clk_i);
      #1;
      wb_rst_i = 1'b0;

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // Abort in COMPARE on a would-be clean hit: no ack, no invalidate.
      begin
         int acks = 0, invs = 0;
         set_line(vecs[1]);
         snoop_req_i = 1'b1;
         repeat (2) @(posedge wb_clk_i);
         #1;
         check("abort_cmp stall", {63'd0, snoop_stall_o}, 64'd1);
         snoop_req_i = 1'b0;
         for (int k = 0; k < 6; k++) begin
            @(posedge wb_clk_i);
            #1;
            if (snoop_ack_o) acks++;
            if (inv_we_o) invs++;
         end
         check("abort_cmp acks", acks, 0);
         check("abort_cmp invs", invs, 0);
         check("abort_cmp idle", {63'd0, snoop_stall_o}, 64'd0);
      end

      // Abort while pending on a busy cache: no tag lookup ever starts.
      begin
         int acks = 0, tags = 0;
         snoop_req_i  = 1'b1;
         cache_busy_i = 1'b1;
         repeat (2) @(posedge wb_clk_i);
         #1;
         check("abort_pend stall", {63'd0, snoop_stall_o}, 64'd1);
         snoop_req_i = 1'b0;
         for (int k = 0; k < 6; k++) begin
            @(posedge wb_clk_i);
            #1;
            if (k == 1) cache_busy_i = 1'b0;
            if (snoop_ack_o) acks++;
            if (tag_rd_en_o) tags++;
         end
         check("abort_pend acks", acks, 0);
         check("abort_pend tag_reads", tags, 0);
         check("abort_pend idle", {63'd0, snoop_stall_o}, 64'd0);
      end

      // A fresh snoop after the aborts behaves normally.
      run_vec(vecs[2], 7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
